// File: rtl/dna_search_dispatcher.sv
// rtl/dna_search_dispatcher.sv - re-issuing pattern-search initiator with a FWFT hit FIFO
// Optional WAIT-state timeout is built when DISPATCH_TIMEOUT_EN is defined.
module dna_search_dispatcher #(
  parameter int PAT_LEN = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        go_i,
  input  logic [15:0] region_start_i,
  input  logic [15:0] region_length_i,
  input  logic [11:0] pat_addr_i,
  output logic        ready_o,
  output logic [15:0] dna_start_o,
  output logic [15:0] dna_length_o,
  output logic [11:0] pattern_start_o,
  input  logic        done_i,
  input  logic        found_it_i,
  input  logic        error_i,
  input  logic [15:0] found_location_i,
  input  logic        hit_rd_i,
  output logic        hit_valid_o,
  output logic [15:0] hit_loc_o,
  output logic [7:0]  hit_count_o,
  output logic        busy_o,
  output logic        finished_o,
  output logic        fault_o,
  output logic        overflow_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [16:0] PAT17   = 17'(PAT_LEN);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_FINISH
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        finished_q;
  logic        fault_q;
  logic        overflow_q;
  logic [15:0] dna_start_q;
  logic [15:0] dna_length_q;
  logic [11:0] pattern_start_q;
  logic [15:0] cur_start_q;
  logic [16:0] end_q;
  logic [7:0]  hit_count_q;
  logic        found_q;
  logic        err_q;
  logic [15:0] loc_q;

  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [16:0] loc_ext;
  logic [16:0] next_start_d;
  logic [16:0] remain_d;
  logic        in_range;
  logic        valid_hit;

`ifdef DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
`else
  logic        unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // All hit arithmetic is 17-bit so a region ending at or past 64K stays correct.
  assign loc_ext      = {1'b0, loc_q};
  assign next_start_d = loc_ext + 17'd1;
  assign remain_d     = end_q - next_start_d;
  assign in_range     = (loc_ext >= {1'b0, cur_start_q}) && ((loc_ext + PAT17) <= end_q);
  assign valid_hit    = (state_q == S_EVAL) && !err_q && found_q && in_range;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = valid_hit && !fifo_full;
  assign pop        = hit_rd_i && !fifo_empty;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      ready_q         <= 1'b0;
      finished_q      <= 1'b0;
      fault_q         <= 1'b0;
      overflow_q      <= 1'b0;
      dna_start_q     <= '0;
      dna_length_q    <= '0;
      pattern_start_q <= '0;
      cur_start_q     <= '0;
      end_q           <= '0;
      hit_count_q     <= '0;
      found_q         <= 1'b0;
      err_q           <= 1'b0;
      loc_q           <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      ready_q    <= 1'b0;
      finished_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            pattern_start_q <= pat_addr_i;
            cur_start_q     <= region_start_i;
            end_q           <= {1'b0, region_start_i} + {1'b0, region_length_i};
            fault_q         <= 1'b0;
            overflow_q      <= 1'b0;
            hit_count_q     <= '0;
            if ({1'b0, region_length_i} < PAT17) begin
              state_q <= S_FINISH;
            end else begin
              state_q      <= S_ISSUE;
              ready_q      <= 1'b1;
              dna_start_q  <= region_start_i;
              dna_length_q <= region_length_i;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (done_i) begin
            found_q <= found_it_i;
            err_q   <= error_i;
            loc_q   <= found_location_i;
            state_q <= S_EVAL;
`ifdef DISPATCH_TIMEOUT_EN
          end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
            fault_q <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
          end
        end
        S_EVAL: begin
          if (err_q) begin
            fault_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (!found_q) begin
            state_q <= S_FINISH;
          end else if (!in_range) begin
            fault_q <= 1'b1;
            state_q <= S_FINISH;
          end else if (fifo_full) begin
            // A pop in this same cycle does not make room: the hit is dropped.
            overflow_q <= 1'b1;
            fault_q    <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            if (hit_count_q != 8'hFF) begin
              hit_count_q <= hit_count_q + 8'd1;
            end
            cur_start_q <= next_start_d[15:0];
            if (remain_d < PAT17) begin
              state_q <= S_FINISH;
            end else begin
              state_q      <= S_ISSUE;
              ready_q      <= 1'b1;
              dna_start_q  <= next_start_d[15:0];
              dna_length_q <= remain_d[15:0];
            end
          end
        end
        S_FINISH: begin
          finished_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= loc_q;
    end
  end

  assign ready_o         = ready_q;
  assign dna_start_o     = dna_start_q;
  assign dna_length_o    = dna_length_q;
  assign pattern_start_o = pattern_start_q;
  assign hit_valid_o     = !fifo_empty;
  assign hit_loc_o       = fifo_empty ? 16'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign hit_count_o     = hit_count_q;
  assign busy_o          = (state_q != S_IDLE);
  assign finished_o      = finished_q;
  assign fault_o         = fault_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_dna_search_dispatcher.sv
// tb/tb_dna_search_dispatcher.sv - randomized self-checking bench for dna_search_dispatcher
// Timeout checks are compiled in when DISPATCH_TIMEOUT_EN is defined.
module tb_dna_search_dispatcher;

  localparam int PAT   = 8;
  localparam int DEPTH = 4;
  localparam int K_NOHIT = 0;
  localparam int K_HIT   = 1;
  localparam int K_BAD   = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int kind;
    int loc;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset, go, done, found_it, error, hit_rd;
  logic [15:0] region_start, region_length, found_location;
  logic [11:0] pat_addr;
  logic        ready, hit_valid, busy, finished, fault, overflow;
  logic [15:0] dna_start, dna_length, hit_loc;
  logic [11:0] pattern_start;
  logic [7:0]  hit_count;

  always #5 clock = ~clock;

  dna_search_dispatcher #(.PAT_LEN(PAT), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clock_i(clock), .reset_i(reset), .go_i(go),
    .region_start_i(region_start), .region_length_i(region_length), .pat_addr_i(pat_addr),
    .ready_o(ready), .dna_start_o(dna_start), .dna_length_o(dna_length),
    .pattern_start_o(pattern_start), .done_i(done), .found_it_i(found_it), .error_i(error),
    .found_location_i(found_location), .hit_rd_i(hit_rd), .hit_valid_o(hit_valid),
    .hit_loc_o(hit_loc), .hit_count_o(hit_count), .busy_o(busy), .finished_o(finished),
    .fault_o(fault), .overflow_o(overflow)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    mq[$];
  resp_t script[$];
  int    obs_start[$];
  int    obs_len[$];
  int    m_end, m_cur, m_count, last_issues;
  bit    m_fault, m_ovf, dense;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic resp_t next_resp();
    resp_t r;
    int    p, span;
    if (script.size() > 0) begin
      r = script.pop_front();
    end else if (dense) begin
      r = '{K_HIT, m_cur};
    end else begin
      p    = int'($urandom_range(0, 99));
      span = m_end - PAT - m_cur;
      if (span > 40) span = 40;
      if (p < 5) r = '{K_ERR, 0};
      else if (p < 10) r = '{K_BAD, (m_cur > 0 && p < 8) ? m_cur - 1 : m_end - PAT + 1 + int'($urandom_range(0, 3))};
      else if (p < 30) r = '{K_NOHIT, int'($urandom_range(0, 65535))};
      else r = '{K_HIT, m_cur + int'($urandom_range(0, span))};
    end
    return r;
  endfunction

  // One clock; an optional host pop is checked against the head of the model FIFO.
  task automatic cycle(input int pop_pct);
    int tmp;
    if (pop_pct > 0 && int'($urandom_range(0, 99)) < pop_pct) begin
      hit_rd = 1'b1;
      check_eq("hit_valid_at_pop", hit_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check_eq("hit_loc_at_pop", hit_loc, mq[0]);
        tmp = mq.pop_front();
      end
    end
    @(negedge clock);
    hit_rd = 1'b0;
  endtask

  task automatic run(input int rs, input int rl, input logic [11:0] pa, input int pop_pct,
                     input int rst_iter);
    bit    more, full;
    resp_t r;
    int    iter;
    m_end = rs + rl; m_cur = rs; m_count = 0; m_fault = 0; m_ovf = 0;
    obs_start.delete(); obs_len.delete();
    region_start = 16'(rs); region_length = 16'(rl); pat_addr = pa; go = 1'b1;
    @(negedge clock);
    go = 1'b0; region_start = 16'($urandom); region_length = 16'($urandom); pat_addr = 12'($urandom);
    check_eq("busy_after_go", busy, 1);
    more = (rl >= PAT);
    iter = 0;
    while (more) begin
      check_eq("ready_issue", ready, 1);
      check_eq("dna_start", dna_start, m_cur);
      check_eq("dna_length", dna_length, m_end - m_cur);
      check_eq("pattern_start", pattern_start, pa);
      obs_start.push_back(int'(dna_start)); obs_len.push_back(int'(dna_length));
      done = 1'($urandom); found_it = 1'b1; error = 1'($urandom); found_location = 16'(m_cur);
      cycle(pop_pct);
      done = 1'b0;
      iter++;
      if (iter == rst_iter) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hit_valid", hit_valid, 0);
        check_eq("rst_hit_count", hit_count, 0);
        check_eq("rst_dna_start", dna_start, 0);
        mq.delete();
        last_issues = iter;
        return;
      end
      check_eq("ready_one_cycle", ready, 0);
      repeat ($urandom_range(0, 4)) begin
        check_eq("ready_wait", ready, 0);
        cycle(pop_pct);
      end
      r = next_resp();
      done = 1'b1; found_it = (r.kind == K_HIT || r.kind == K_BAD);
      error = (r.kind == K_ERR); found_location = 16'(r.loc);
      cycle(pop_pct);
      done = 1'b0; found_it = 1'($urandom); error = 1'($urandom); found_location = 16'($urandom);
      full = (mq.size() == DEPTH);
      cycle(pop_pct);
      if (r.kind == K_ERR) begin
        m_fault = 1; more = 0;
      end else if (r.kind == K_NOHIT) begin
        more = 0;
      end else if (r.loc < m_cur || r.loc + PAT > m_end) begin
        m_fault = 1; more = 0;
      end else if (full) begin
        m_fault = 1; m_ovf = 1; more = 0;
      end else begin
        mq.push_back(r.loc);
        if (m_count < 255) m_count++;
        m_cur = r.loc + 1;
        more = (m_end - m_cur >= PAT);
      end
    end
    last_issues = iter;
    check_eq("ready_in_finish", ready, 0);
    check_eq("finished_early", finished, 0);
    cycle(pop_pct);
    check_eq("finished_pulse", finished, 1);
    check_eq("busy_idle", busy, 0);
    cycle(pop_pct);
    check_eq("finished_one_cycle", finished, 0);
    check_eq("fault", fault, m_fault);
    check_eq("overflow", overflow, m_ovf);
    check_eq("hit_count", hit_count, m_count);
    check_eq("hit_valid_after_run", hit_valid, mq.size() > 0);
  endtask

  task automatic drain();
    int n;
    n = mq.size();
    repeat (n) cycle(100);
    check_eq("hit_valid_drained", hit_valid, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; go = 1'b0; done = 1'b0; found_it = 1'b0; error = 1'b0; hit_rd = 1'b0;
    region_start = '0; region_length = '0; found_location = '0; pat_addr = '0; dense = 0;
    repeat (3) @(negedge clock);
    check_eq("reset_ready", ready, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_hit_valid", hit_valid, 0);
    check_eq("reset_hit_loc", hit_loc, 0);
    check_eq("reset_hit_count", hit_count, 0);
    check_eq("reset_flags", {finished, fault, overflow}, 0);
    check_eq("reset_dna", {dna_start, dna_length}, 0);
    check_eq("reset_pattern", pattern_start, 0);
    reset = 1'b0;
    @(negedge clock);

    script.push_back('{K_NOHIT, 0});
    run(5, 100, 12'h0A5, 0, -1);
    check_eq("nohit_issues", last_issues, 1);

    script = '{'{K_HIT, 20}, '{K_HIT, 47}, '{K_HIT, 90}, '{K_NOHIT, 0}};
    run(5, 100, 12'h123, 0, -1);
    check_eq("multi_issues", last_issues, 4);
    check_eq("multi_start2", obs_start[1], 21);
    check_eq("multi_len2", obs_len[1], 84);
    check_eq("multi_start3", obs_start[2], 48);
    check_eq("multi_len3", obs_len[2], 57);
    check_eq("multi_start4", obs_start[3], 91);
    check_eq("multi_len4", obs_len[3], 14);
    check_eq("multi_count", hit_count, 3);
    drain();

    script = '{'{K_HIT, 32}};
    run(0, 40, 12'h7FF, 0, -1);
    check_eq("tail_issues", last_issues, 1);
    check_eq("tail_count", hit_count, 1);
    drain();

    script = '{'{K_BAD, 33}};
    run(0, 40, 12'h001, 0, -1);
    check_eq("upper_bad_fault", fault, 1);

    script = '{'{K_HIT, 10}, '{K_HIT, 20}, '{K_HIT, 30}, '{K_HIT, 40}, '{K_HIT, 50}};
    run(0, 100, 12'h055, 0, -1);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_fault", fault, 1);
    check_eq("ovf_count", hit_count, DEPTH);
    drain();

    script = '{'{K_BAD, 3}};
    run(5, 100, 12'h0F0, 0, -1);
    check_eq("badloc_fault", fault, 1);
    check_eq("badloc_empty", hit_valid, 0);

    script = '{'{K_ERR, 0}};
    run(5, 100, 12'h00F, 0, -1);
    check_eq("error_fault", fault, 1);

    run(5, 7, 12'h321, 0, -1);
    check_eq("short_issues", last_issues, 0);
    check_eq("short_fault_cleared", fault, 0);
    script = '{'{K_NOHIT, 0}};
    run(5, 8, 12'h321, 0, -1);
    check_eq("exact_len_issues", last_issues, 1);

    script = '{'{K_HIT, 10}};
    run(0, 100, 12'h444, 0, 2);

    repeat (40) begin
      run(int'($urandom_range(0, 30000)), int'($urandom_range(0, 120)), 12'($urandom), 30, -1);
      if ($urandom_range(0, 1)) drain();
    end
    drain();

    dense = 1;
    run(0, 300, 12'h999, 100, -1);
    dense = 0;
    check_eq("count_saturated", hit_count, 255);
    drain();

`ifdef DISPATCH_TIMEOUT_EN
    region_start = 16'd0; region_length = 16'd100; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check_eq("to_ready", ready, 1);
    @(negedge clock);
    repeat (15) @(negedge clock);
    check_eq("to_not_yet", fault, 0);
    @(negedge clock);
    check_eq("to_fault", fault, 1);
    done = 1'b1; found_it = 1'b1; found_location = 16'd10;
    @(negedge clock);
    done = 1'b0;
    check_eq("to_finished", finished, 1);
    @(negedge clock);
    check_eq("to_late_done_ignored", hit_valid, 0);
    check_eq("to_late_count", hit_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
